cnn_batch_sequencer: RTL

- Synthesizable on-chip driver for `cnn_multichannel_top`.
- Runs a batch of test images through the classifier, one image at a time:
  - reads the 8-bit pixels and labels from synchronous image/label RAMs;
  - pulses the CNN reset before each image;
  - streams the 784 pixels back-to-back;
  - waits for `fc_done` and scores `final_digit` against the label.
- Exposes the running correct count, so accuracy is measured in hardware instead of only in simulation.

---
 rtl/cnn_batch_sequencer_pkg.sv | 29 ++
 rtl/cnn_batch_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_batch_sequencer_pkg.sv
// Shared definitions for the CNN batch sequencer.
// Holds the sequencer state encoding, the pixels-per-image derivation,
// the width of the label nibble that is scored, and a small helper used
// to size internal counters.
package cnn_batch_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CRST   = 3'd1,
        ST_CREC   = 3'd2,
        ST_STREAM = 3'd3,
        ST_WAIT   = 3'd4,
        ST_SCORE  = 3'd5,
        ST_GAP    = 3'd6,
        ST_FIN    = 3'd7
    } state_e;

    // Only the low nibble of a label byte carries the digit.
    localparam int LBL_NIB_W = 4;

    function automatic int img_pix(input int img_w);
        return img_w * img_w;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cnn_batch_sequencer.sv
// On-chip batch driver for the multichannel CNN classifier.
// For each image of a batch it resets the CNN, streams the image pixels out of
// a synchronous image RAM, waits for the classifier result (with a timeout)
// and scores it against the label read from a synchronous label RAM.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - one-cycle pulse that begins a batch (ignored while busy)
//   img_addr / img_data - image RAM read port, 1-cycle read latency
//   lbl_addr / lbl_data - label RAM read port, 1-cycle read latency
//   cnn_rst_n, cnn_valid, cnn_data - reset and pixel stream towards the CNN
//   cnn_done, cnn_digit - classifier completion and result
//   busy, done, img_idx, correct_cnt, miss, timeout_err - batch status
module cnn_batch_sequencer
    import cnn_batch_sequencer_pkg::*;
#(
    parameter int   DATA_W      = 8,
    parameter int   IMG_W       = 28,
    parameter int   NUM_IMG     = 1000,
    parameter int   RST_CYC     = 3,
    parameter int   GAP_CYC     = 25,
    parameter int   TIMEOUT_CYC = 65535,
    localparam int  IMG_PIX     = img_pix(IMG_W),
    localparam int  ADDR_W      = $clog2(NUM_IMG * IMG_PIX),
    localparam int  LBL_W       = $clog2(NUM_IMG),
    localparam int  IDX_W       = $clog2(NUM_IMG + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] img_addr,
    input  logic [DATA_W-1:0] img_data,
    output logic [LBL_W-1:0]  lbl_addr,
    input  logic [7:0]        lbl_data,
    output logic              cnn_rst_n,
    output logic              cnn_valid,
    output logic [DATA_W-1:0] cnn_data,
    input  logic              cnn_done,
    input  logic [3:0]        cnn_digit,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  img_idx,
    output logic [IDX_W-1:0]  correct_cnt,
    output logic              miss,
    output logic              timeout_err
);

    localparam int CNT_MAX = max2(max2(IMG_PIX, RST_CYC), max2(GAP_CYC, TIMEOUT_CYC));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] img_addr_q, img_addr_d;
    logic [LBL_W-1:0]  lbl_addr_q, lbl_addr_d;
    logic              cnn_rst_n_q, cnn_rst_n_d;
    logic              cnn_valid_q, cnn_valid_d;
    logic [DATA_W-1:0] cnn_data_q, cnn_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [IDX_W-1:0]  img_idx_q, img_idx_d;
    logic [IDX_W-1:0]  correct_q, correct_d;
    logic              miss_q, miss_d;
    logic              timeout_q, timeout_d;
    logic              hit_q, hit_d;
    logic              accept_s, wait_exit_s, match_s, expire_s;
    logic              unused_lbl_hi;

    assign unused_lbl_hi = ^lbl_data[7:LBL_NIB_W];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; cnt_q restarts from zero on every state change.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_CRST; else state_d = ST_IDLE;
            ST_CRST:   if (cnt_q == CNT_W'(RST_CYC - 1)) state_d = ST_CREC; else state_d = ST_CRST;
            ST_CREC:   if (cnt_q == CNT_W'(RST_CYC - 1)) state_d = ST_STREAM; else state_d = ST_CREC;
            ST_STREAM: if (cnt_q == CNT_W'(IMG_PIX - 1)) state_d = ST_WAIT; else state_d = ST_STREAM;
            ST_WAIT:   if (cnn_done || (cnt_q == CNT_W'(TIMEOUT_CYC - 1))) state_d = ST_SCORE;
                       else state_d = ST_WAIT;
            ST_SCORE:  if (img_idx_q == IDX_W'(NUM_IMG - 1)) state_d = ST_FIN; else state_d = ST_GAP;
            ST_GAP:    if (cnt_q == CNT_W'(GAP_CYC - 1)) state_d = ST_CRST; else state_d = ST_GAP;
            ST_FIN:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; every output is registered from these.
    always_comb begin
        accept_s    = (state_q == ST_IDLE) && start;
        wait_exit_s = (state_q == ST_WAIT) && (state_d == ST_SCORE);
        match_s     = cnn_done && (cnn_digit == lbl_data[LBL_NIB_W-1:0]);
        // A done arriving on the expiring cycle wins over the timeout.
        expire_s    = wait_exit_s && !cnn_done;

        if ((state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_FIN)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        cnn_rst_n_d = (state_d != ST_CRST);
        busy_d      = (state_d != ST_IDLE) && (state_d != ST_FIN);
        cnn_valid_d = (state_q == ST_STREAM);
        if (state_q == ST_STREAM) begin
            cnn_data_d = img_data;
        end else begin
            cnn_data_d = '0;
        end

        if (accept_s) begin
            img_idx_d = '0;
        end else if (state_q == ST_SCORE) begin
            img_idx_d = img_idx_q + IDX_W'(1);
        end else begin
            img_idx_d = img_idx_q;
        end

        if (accept_s) begin
            done_d = 1'b0;
        end else if (state_d == ST_FIN) begin
            done_d = 1'b1;
        end else begin
            done_d = done_q;
        end

        if (accept_s) begin
            correct_d = '0;
        end else if ((state_q == ST_SCORE) && hit_q && (correct_q < IDX_W'(NUM_IMG))) begin
            correct_d = correct_q + IDX_W'(1);
        end else begin
            correct_d = correct_q;
        end

        if (accept_s) begin
            timeout_d = 1'b0;
        end else if (expire_s) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_q;
        end

        // Scoring is resolved on the WAIT exit edge so miss is visible during SCORE.
        if (wait_exit_s) begin
            hit_d = match_s;
        end else begin
            hit_d = hit_q;
        end
        miss_d = wait_exit_s && !match_s;

        if (state_d == ST_CRST) begin
            lbl_addr_d = LBL_W'(img_idx_d);
        end else begin
            lbl_addr_d = lbl_addr_q;
        end

        // Base address is parked through CRST/CREC, then the address leads the
        // data by one cycle and stops at the image's last pixel.
        if ((state_d == ST_CRST) || (state_d == ST_CREC)) begin
            img_addr_d = ADDR_W'(img_idx_d) * ADDR_W'(IMG_PIX);
        end else if ((state_q == ST_CREC) && (state_d == ST_STREAM)) begin
            img_addr_d = img_addr_q + ADDR_W'(1);
        end else if ((state_q == ST_STREAM) && (cnt_q < CNT_W'(IMG_PIX - 2))) begin
            img_addr_d = img_addr_q + ADDR_W'(1);
        end else begin
            img_addr_d = img_addr_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            img_addr_q  <= '0;
            lbl_addr_q  <= '0;
            cnn_rst_n_q <= 1'b0;
            cnn_valid_q <= 1'b0;
            cnn_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            img_idx_q   <= '0;
            correct_q   <= '0;
            miss_q      <= 1'b0;
            timeout_q   <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            img_addr_q  <= img_addr_d;
            lbl_addr_q  <= lbl_addr_d;
            cnn_rst_n_q <= cnn_rst_n_d;
            cnn_valid_q <= cnn_valid_d;
            cnn_data_q  <= cnn_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            img_idx_q   <= img_idx_d;
            correct_q   <= correct_d;
            miss_q      <= miss_d;
            timeout_q   <= timeout_d;
            hit_q       <= hit_d;
        end
    end

    assign img_addr    = img_addr_q;
    assign lbl_addr    = lbl_addr_q;
    assign cnn_rst_n   = cnn_rst_n_q;
    assign cnn_valid   = cnn_valid_q;
    assign cnn_data    = cnn_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign img_idx     = img_idx_q;
    assign correct_cnt = correct_q;
    assign miss        = miss_q;
    assign timeout_err = timeout_q;

endmodule
